bus_sequencer: RTL

- Control-unit FSM for the basic sysbus processor.
- Drives the bus-enable, register-load and memory-control strobes consumed by the program ROM, the RAM, PC, IR, ACC and ALU, so it sits directly upstream of the ROM's MAR/MDR controls.
- Runs the fetch–decode–execute cycle for the 3-bit opcode set.
- Counts retired instructions and reports a halted status.

---
 rtl/seq_pkg.sv | 50 +++++
 rtl/sat_counter.sv | 16 +
 rtl/bus_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the sysbus control unit: opcodes, ALU function codes,
// sequencer states and the bundle of control strobes it drives.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_XOR   = 3'b100,
    OP_BNE   = 3'b101,
    OP_BRA   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_XOR  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0,
    S_FETCH_MEM  = 4'd1,
    S_FETCH_IR   = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC_RD    = 4'd4,
    S_EXEC_WB    = 4'd5,
    S_EXEC_ST1   = 4'd6,
    S_EXEC_ST2   = 4'd7,
    S_HALT       = 4'd8
  } state_e;

  typedef struct packed {
    logic       acc_bus;
    logic       load_acc;
    logic       pc_bus;
    logic       load_pc;
    logic       inc_pc;
    logic       load_ir;
    logic       addr_bus;
    logic       load_mar;
    logic       mdr_bus;
    logic       load_mdr;
    logic       cs;
    logic       r_nw;
    logic       alu_acc;
    logic [1:0] alu_op;
  } strb_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Fetch-decode-execute control FSM for the basic sysbus processor, plus a
// saturating retired-instruction counter.
module bus_sequencer
  import seq_pkg::*;
#(
  parameter int WORD_W = 10,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  output logic             ACC_bus,
  output logic             load_ACC,
  output logic             PC_bus,
  output logic             load_PC,
  output logic             INC_PC,
  output logic             load_IR,
  output logic             Addr_bus,
  output logic             load_MAR,
  output logic             MDR_bus,
  output logic             load_MDR,
  output logic             CS,
  output logic             R_NW,
  output logic             ALU_ACC,
  output logic [1:0]       ALU_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  if (WORD_W <= OP_W) begin : g_bad_width
    $error("bus_sequencer: WORD_W must exceed OP_W to leave an address field");
  end

  state_e  st, nxt;
  opcode_e opc;
  strb_t   s;
  logic    retire;

  assign opc = opcode_e'(op[2:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) st <= S_FETCH_ADDR;
    else       st <= nxt;
  end

  always_comb begin
    nxt      = st;
    s        = '0;
    s.r_nw   = 1'b1;
    s.alu_op = ALU_PASS;
    retire   = 1'b0;
    case (st)
      S_FETCH_ADDR: begin
        s.pc_bus   = 1'b1;
        s.load_mar = 1'b1;
        s.inc_pc   = 1'b1;
        nxt        = S_FETCH_MEM;
      end
      S_FETCH_MEM: begin
        s.cs       = 1'b1;
        s.load_mdr = 1'b1;
        nxt        = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        s.mdr_bus  = 1'b1;
        s.load_ir  = 1'b1;
        nxt        = S_DECODE;
      end
      S_DECODE: begin
        case (opc)
          OP_BNE: begin
            s.addr_bus = !z_flag;
            s.load_pc  = !z_flag;
            retire     = 1'b1;
            nxt        = S_FETCH_ADDR;
          end
          OP_BRA: begin
            s.addr_bus = 1'b1;
            s.load_pc  = 1'b1;
            retire     = 1'b1;
            nxt        = S_FETCH_ADDR;
          end
          OP_HALT: begin
            retire     = 1'b1;
            nxt        = S_HALT;
          end
          OP_STORE: begin
            s.addr_bus = 1'b1;
            s.load_mar = 1'b1;
            nxt        = S_EXEC_ST1;
          end
          OP_LOAD, OP_ADD, OP_SUB, OP_XOR: begin
            s.addr_bus = 1'b1;
            s.load_mar = 1'b1;
            nxt        = S_EXEC_RD;
          end
          default: nxt = S_FETCH_ADDR;
        endcase
      end
      S_EXEC_RD: begin
        s.cs       = 1'b1;
        s.load_mdr = 1'b1;
        nxt        = S_EXEC_WB;
      end
      S_EXEC_WB: begin
        s.mdr_bus  = 1'b1;
        s.load_acc = 1'b1;
        retire     = 1'b1;
        nxt        = S_FETCH_ADDR;
        // LOAD (and anything unexpected) passes the bus value straight through
        case (opc)
          OP_ADD: begin s.alu_acc = 1'b1; s.alu_op = ALU_ADD; end
          OP_SUB: begin s.alu_acc = 1'b1; s.alu_op = ALU_SUB; end
          OP_XOR: begin s.alu_acc = 1'b1; s.alu_op = ALU_XOR; end
          default: ;
        endcase
      end
      S_EXEC_ST1: begin
        s.acc_bus  = 1'b1;
        s.load_mdr = 1'b1;
        s.r_nw     = 1'b0;
        nxt        = S_EXEC_ST2;
      end
      S_EXEC_ST2: begin
        s.cs       = 1'b1;
        s.r_nw     = 1'b0;
        retire     = 1'b1;
        nxt        = S_FETCH_ADDR;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH_ADDR;
    endcase
    // Reset aborts the current step immediately: no strobe survives it.
    if (reset) begin
      s        = '0;
      s.r_nw   = 1'b1;
      s.alu_op = ALU_PASS;
      retire   = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (retire),
    .count (instr_count)
  );

  assign ACC_bus  = s.acc_bus;
  assign load_ACC = s.load_acc;
  assign PC_bus   = s.pc_bus;
  assign load_PC  = s.load_pc;
  assign INC_PC   = s.inc_pc;
  assign load_IR  = s.load_ir;
  assign Addr_bus = s.addr_bus;
  assign load_MAR = s.load_mar;
  assign MDR_bus  = s.mdr_bus;
  assign load_MDR = s.load_mdr;
  assign CS       = s.cs;
  assign R_NW     = s.r_nw;
  assign ALU_ACC  = s.alu_acc;
  assign ALU_op   = s.alu_op;
  assign halted   = (st == S_HALT);

endmodule
